sm83_mem_resp: RTL and testbench

Memory-side responder for the SM83 address/data bus. It accepts CPU read and write strobes against the CPU's 16-bit address pins and forwards them to a backing memory port using a req/ack handshake. It returns data and a one-cycle ready pulse to the CPU. A single-entry sequential prefetch buffer speculatively fetches address A+1 after each read, so linear instruction fetches complete with one cycle of latency.

---
 rtl/sm83_mem_pkg.sv | 20 ++
 rtl/sm83_mem_pfbuf.sv | 53 +++++
 rtl/sm83_mem_resp.sv | 196 +++++++++++++++++++
 tb/tb_sm83_mem_resp.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_mem_pkg.sv
// Shared types for the SM83 memory responder: FSM states, CPU address layout
// and the default start of the side-effecting I/O window.
package sm83_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_MISS,
    ST_WR,
    ST_PF,
    ST_PF_HOLD
  } mem_state_t;

  typedef struct packed {
    logic [7:0] hi;
    logic [7:0] lo;
  } adr_t;

  localparam int unsigned IO_BASE_DEF = 32'h0000_ff00;

endpackage

// File: rtl/sm83_mem_pfbuf.sv
// Single-entry sequential prefetch buffer: tag/data/valid plus the hit
// comparator shared by the IDLE lookup and the PF_HOLD resolution.
module sm83_mem_pfbuf
  import sm83_mem_pkg::*;
#(
  parameter int          ADR_WIDTH = 16,
  parameter int unsigned IO_BASE   = IO_BASE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADR_WIDTH-1:0] lookup_adr,
  input  logic                 launch,
  input  logic [ADR_WIDTH-1:0] launch_adr,
  input  logic                 load,
  input  logic [7:0]           load_data,
  input  logic                 invalidate,
  input  logic                 snoop_v,
  input  logic [ADR_WIDTH-1:0] snoop_adr,
  output logic                 hit,
  output logic                 tag_eq,
  output logic [7:0]           data
);

  localparam logic [ADR_WIDTH-1:0] IO_LIM = ADR_WIDTH'(IO_BASE);

  logic                 valid;
  logic [ADR_WIDTH-1:0] tag;
  logic [7:0]           data_q;

  assign tag_eq = (tag == lookup_adr);
  assign hit    = valid && tag_eq && (lookup_adr < IO_LIM);
  assign data   = data_q;

  // A launch retags and empties the entry; the data arrives later via load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid  <= 1'b0;
      tag    <= '0;
      data_q <= '0;
    end else if (launch) begin
      tag   <= launch_adr;
      valid <= 1'b0;
    end else begin
      if (load) begin
        data_q <= load_data;
        valid  <= (tag < IO_LIM);
      end
      if (invalidate || (snoop_v && snoop_adr == tag))
        valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sm83_mem_resp.sv
// SM83 bus responder: turns CPU rd/wr strobes into req/ack memory cycles and
// speculatively fetches A+1 after every read so linear fetches hit.
module sm83_mem_resp
  import sm83_mem_pkg::*;
#(
  parameter int          ADR_WIDTH = 16,
  parameter int unsigned IO_BASE   = IO_BASE_DEF,
  parameter bit          PREFETCH  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADR_WIDTH-1:0] apin,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  input  logic [7:0]           cpu_din,
  output logic [7:0]           cpu_dout,
  output logic                 cpu_ready,
  output logic [ADR_WIDTH-1:0] mem_adr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ack
);

  localparam logic [ADR_WIDTH-1:0] IO_LIM = ADR_WIDTH'(IO_BASE);

  mem_state_t state, state_nxt;

  logic                 req_v;
  logic [ADR_WIDTH-1:0] hold_adr;
  logic [7:0]           hold_wdata;
  logic                 hold_wr;

  logic                 in_hold;
  logic [ADR_WIDTH-1:0] eff_adr;
  logic [7:0]           eff_wdata;
  logic                 eff_wr;

  logic                 buf_hit, buf_tag_eq;
  logic [7:0]           buf_data;
  logic                 res_hit;

  logic                 go_issue, go_done, hold_ld, pf_load, wr_done, pf_ok;
  logic [ADR_WIDTH-1:0] done_adr, pf_adr;
  logic [7:0]           done_data;

  logic [7:0]           dout_nxt, wdata_nxt;
  logic [ADR_WIDTH-1:0] adr_nxt;
  logic                 ready_nxt, rd_nxt, wr_nxt;

  // rd+wr together counts as a write.
  assign req_v     = cpu_rd | cpu_wr;
  assign in_hold   = (state == ST_PF_HOLD);
  assign eff_adr   = in_hold ? hold_adr   : apin;
  assign eff_wdata = in_hold ? hold_wdata : cpu_din;
  assign eff_wr    = in_hold ? hold_wr    : cpu_wr;

  // Outside IDLE a hit means the in-flight prefetch is exactly what was asked for.
  assign res_hit = !eff_wr &&
                   ((state == ST_IDLE) ? buf_hit : (buf_tag_eq && eff_adr < IO_LIM));

  sm83_mem_pfbuf #(
    .ADR_WIDTH (ADR_WIDTH),
    .IO_BASE   (IO_BASE)
  ) u_pfbuf (
    .clk        (clk),
    .reset      (reset),
    .lookup_adr (eff_adr),
    .launch     (go_done && pf_ok),
    .launch_adr (pf_adr),
    .load       (pf_load),
    .load_data  (mem_rdata),
    .invalidate (go_issue && res_hit),
    .snoop_v    (go_issue && eff_wr),
    .snoop_adr  (eff_adr),
    .hit        (buf_hit),
    .tag_eq     (buf_tag_eq),
    .data       (buf_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // go_issue: serve a request as IDLE would; go_done: a read completes now.
  always_comb begin
    state_nxt = state;
    go_issue  = 1'b0;
    go_done   = 1'b0;
    hold_ld   = 1'b0;
    pf_load   = 1'b0;
    wr_done   = 1'b0;
    done_adr  = mem_adr;
    done_data = mem_rdata;
    case (state)
      ST_IDLE:    go_issue = req_v;
      ST_RD_MISS: go_done  = mem_ack;
      ST_WR: begin
        if (mem_ack) begin
          wr_done   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_PF: begin
        if (mem_ack) begin
          if (req_v) begin
            go_issue = 1'b1;
          end else begin
            pf_load   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (req_v) begin
          hold_ld   = 1'b1;
          state_nxt = ST_PF_HOLD;
        end
      end
      ST_PF_HOLD: go_issue = mem_ack;
      default:    state_nxt = ST_IDLE;
    endcase

    if (go_issue) begin
      if (eff_wr) begin
        state_nxt = ST_WR;
      end else if (res_hit) begin
        go_done   = 1'b1;
        done_adr  = eff_adr;
        done_data = (state == ST_IDLE) ? buf_data : mem_rdata;
      end else begin
        state_nxt = ST_RD_MISS;
      end
    end

    pf_adr = done_adr + ADR_WIDTH'(1);
    pf_ok  = PREFETCH && (pf_adr < IO_LIM);
    if (go_done) state_nxt = pf_ok ? ST_PF : ST_IDLE;
  end

  // mem_rd stays high across a read completion when the prefetch follows.
  always_comb begin
    dout_nxt  = cpu_dout;
    ready_nxt = 1'b0;
    adr_nxt   = mem_adr;
    rd_nxt    = mem_rd;
    wr_nxt    = mem_wr;
    wdata_nxt = mem_wdata;
    if (go_issue && eff_wr) begin
      adr_nxt   = eff_adr;
      wdata_nxt = eff_wdata;
      wr_nxt    = 1'b1;
      rd_nxt    = 1'b0;
    end else if (go_issue && !res_hit) begin
      adr_nxt = eff_adr;
      rd_nxt  = 1'b1;
    end
    if (go_done) begin
      dout_nxt  = done_data;
      ready_nxt = 1'b1;
      rd_nxt    = pf_ok;
      if (pf_ok) adr_nxt = pf_adr;
    end
    if (wr_done) begin
      wr_nxt    = 1'b0;
      ready_nxt = 1'b1;
    end
    if (pf_load) rd_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cpu_dout   <= '0;
      cpu_ready  <= 1'b0;
      mem_adr    <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
      hold_adr   <= '0;
      hold_wdata <= '0;
      hold_wr    <= 1'b0;
    end else begin
      cpu_dout  <= dout_nxt;
      cpu_ready <= ready_nxt;
      mem_adr   <= adr_nxt;
      mem_rd    <= rd_nxt;
      mem_wr    <= wr_nxt;
      mem_wdata <= wdata_nxt;
      if (hold_ld) begin
        hold_adr   <= apin;
        hold_wdata <= cpu_din;
        hold_wr    <= cpu_wr;
      end
    end
  end

endmodule

// File: tb/tb_sm83_mem_resp.sv
// Randomized bench for sm83_mem_resp: a latency-randomizing backing memory plus
// a transaction-level model of reads, writes and the speculative A+1 buffer.
module tb_sm83_mem_resp;
  import sm83_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] apin = '0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        cpu_ready;
  logic [15:0] mem_adr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  sm83_mem_resp dut (
    .clk(clk), .reset(reset), .apin(apin), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
    .mem_adr(mem_adr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct { bit wr; logic [15:0] adr; logic [7:0] d; } txn_t;

  logic [7:0]  bmem [65536];
  logic [7:0]  ref_mem [65536];
  txn_t        log_q [$];
  int          cyc = 0, ack_cyc = 0, fixed_dly = 1, dly_cnt = 0;
  bit          active = 0, t_wr = 0;
  logic [15:0] t_adr = '0;
  int          n_chk = 0, n_pass = 0;

  // Model of the prefetch buffer at the behavioural level.
  bit          pf_v = 0;
  logic [15:0] pf_a = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory: logs each new request, acks after a chosen delay.
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      active  = 0;
      mem_ack = 1'b0;
    end else begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        active  = 0;
      end
      if (!active && (mem_rd || mem_wr)) begin
        active = 1;
        t_wr   = mem_wr;
        t_adr  = mem_adr;
        log_q.push_back('{mem_wr, mem_adr, mem_wdata});
        if (mem_wr) bmem[mem_adr] = mem_wdata;
        dly_cnt = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
      end
      if (active && !mem_ack) begin
        if (dly_cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = t_wr ? 8'h00 : bmem[t_adr];
          ack_cyc   = cyc;
        end else begin
          dly_cnt--;
        end
      end
      if (!mem_ack) mem_rdata = 8'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_mem(input logic [15:0] a, input logic [7:0] d);
    bmem[a]    = d;
    ref_mem[a] = d;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_dout"},  32'(cpu_dout),  0);
    chk({pfx, "_ready"}, 32'(cpu_ready), 0);
    chk({pfx, "_rd"},    32'(mem_rd),    0);
    chk({pfx, "_wr"},    32'(mem_wr),    0);
    chk({pfx, "_adr"},   32'(mem_adr),   0);
    chk({pfx, "_wdata"}, 32'(mem_wdata), 0);
  endtask

  task automatic do_req(input bit wr, input bit both, input logic [15:0] a,
                        input logic [7:0] d, input int gap);
    int ls, lat, nexp;
    bit pend, hit;
    logic [15:0] na;
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    chk("ready_pulse", 32'(cpu_ready), 0);
    ls      = log_q.size();
    cpu_rd  = !wr || both;
    cpu_wr  = wr;
    apin    = a;
    cpu_din = d;
    @(posedge clk); #1;
    cpu_rd  = 1'b0;
    cpu_wr  = 1'b0;
    apin    = 16'($urandom);
    cpu_din = 8'($urandom);
    pend = active;
    hit  = !wr && pf_v && (a == pf_a);
    lat  = 1;
    while (!cpu_ready && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ready_seen", 32'(cpu_ready), 1);
    if (hit && !pend) chk("hit_lat", lat, 1);
    else              chk("ack_to_ready", cyc, ack_cyc + 1);
    nexp = hit ? 0 : 1;
    chk("mem_txn_cnt", log_q.size() - ls, nexp);
    if (nexp == 1 && log_q.size() > ls) begin
      chk("txn_type", 32'(log_q[ls].wr), 32'(wr));
      chk("txn_adr", 32'(log_q[ls].adr), 32'(a));
      if (wr) chk("txn_wdata", 32'(log_q[ls].d), 32'(d));
    end
    if (wr) begin
      ref_mem[a] = d;
      chk("wr_idle", 32'({mem_rd, mem_wr}), 0);
      pf_v = pf_v && !pend && (a != pf_a);
    end else begin
      chk("rdata", 32'(cpu_dout), 32'(ref_mem[a]));
      na = a + 16'd1;
      if (na < 16'(IO_BASE_DEF)) begin
        pf_v = 1;
        pf_a = na;
        chk("pf_rd", 32'(mem_rd), 1);
        chk("pf_adr", 32'(mem_adr), 32'(na));
      end else begin
        if (hit || pend) pf_v = 0;
        chk("pf_none", 32'(mem_rd), 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, last_a;
    adr_t        ah;
    bit          wr, both;
    int          k;
    for (int i = 0; i < 65536; i++) begin
      bmem[i]    = 8'($urandom);
      ref_mem[i] = bmem[i];
    end
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    reset = 1'b1;

    // Make outputs non-zero, then reset in the middle of a read miss.
    do_req(1, 0, 16'h0050, 8'h77, 1);
    do_req(0, 0, 16'h0050, 8'h00, 0);
    repeat (8) @(posedge clk);
    fixed_dly = 20;
    @(posedge clk); #1;
    cpu_rd = 1'b1;
    apin   = 16'h0100;
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    chk("rdmiss_rd", 32'(mem_rd), 1);
    chk("rdmiss_adr", 32'(mem_adr), 32'h0100);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_mid");
    reset     = 1'b1;
    pf_v      = 0;
    fixed_dly = 2;

    // Linear fetch: miss, then hit on the completed prefetch.
    set_mem(16'h0100, 8'hAA);
    set_mem(16'h0101, 8'h3E);
    do_req(0, 0, 16'h0100, 8'h00, 0);
    chk("plan_aa", 32'(cpu_dout), 32'hAA);
    do_req(0, 0, 16'h0101, 8'h00, 4);
    chk("plan_3e", 32'(cpu_dout), 32'h3E);

    // I/O window: no prefetch across the boundary, I/O reads never hit.
    do_req(0, 0, 16'hFEFF, 8'h00, 5);
    do_req(0, 0, 16'hFF44, 8'h00, 0);
    do_req(0, 0, 16'hFF44, 8'h00, 0);

    // Write and read colliding with a pending prefetch.
    fixed_dly = 5;
    do_req(0, 0, 16'h0200, 8'h00, 5);
    do_req(1, 0, 16'h0201, 8'h55, 0);
    do_req(0, 0, 16'h0201, 8'h00, 0);
    chk("plan_55", 32'(cpu_dout), 32'h55);
    do_req(0, 0, 16'h0300, 8'h00, 3);
    do_req(0, 0, 16'h0301, 8'h00, 0);

    fixed_dly = -1;
    last_a    = 16'h0301;
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 9));
      case (k)
        0, 1, 2, 3: a = pf_v ? pf_a : last_a + 16'd1;
        6: begin
          ah.hi = 8'hFF;
          ah.lo = 8'($urandom);
          a     = ah;
        end
        7: a = ($urandom_range(0, 1) != 0) ? 16'hFEFF : 16'hFFFF;
        default: begin
          ah.hi = 8'h01;
          ah.lo = 8'($urandom_range(0, 15));
          a     = ah;
        end
      endcase
      wr   = ($urandom_range(0, 3) == 0);
      both = wr && ($urandom_range(0, 1) != 0);
      do_req(wr, both, a, 8'($urandom), int'($urandom_range(0, 2)));
      last_a = a;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
